// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock,
// with start/busy/done handshake, leading-zero blanking mask and overflow flag.
module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  ovf
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [BIN_W-1:0] bin_sr;
  logic [4*DIGITS-1:0] work, adj, work_nxt;
  logic ovf_w, ovf_nxt, last;
  logic [CNT_W-1:0] cnt;
  logic [DIGITS:0] nz;
  assign busy = state == SHIFT;
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = work[4*i +: 4] >= 4'd5 ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
    work_nxt = {adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
    ovf_nxt = ovf_w | adj[4*DIGITS-1];
    // nz[i]: some digit at or above i is nonzero in the post-shift result
    nz = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      nz[i] = nz[i+1] | (|work_nxt[4*i +: 4]);
    last = state == SHIFT && cnt == CNT_W'(1);
    state_nxt = state == IDLE ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      work     <= '0;
      ovf_w    <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd_out  <= '0;
      digit_en <= DIGITS'(1);
      ovf      <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE && start) begin
        bin_sr <= bin_in;
        work   <= '0;
        ovf_w  <= 1'b0;
        cnt    <= CNT_W'(BIN_W);
      end else if (state == SHIFT) begin
        bin_sr <= bin_sr << 1;
        work   <= work_nxt;
        ovf_w  <= ovf_nxt;
        cnt    <= cnt - CNT_W'(1);
      end
      if (last) begin
        bcd_out  <= work_nxt;
        ovf      <= ovf_nxt;
        digit_en <= ovf_nxt ? '1 : nz[DIGITS-1:0] | DIGITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (32-bit/10-digit and 8-bit/2-digit instances)
// against a divide-by-ten reference model.
module tb_bin2bcd_seq;
  typedef struct {logic [39:0] bcd; logic [9:0] en; logic ovf; longint cyc;} exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic start_a, busy_a, done_a, ovf_a;
  logic [31:0] bin_a;
  logic [39:0] bcd_a;
  logic [9:0] en_a;
  logic start_b, busy_b, done_b, ovf_b;
  logic [7:0] bin_b, bcd_b;
  logic [1:0] en_b;
  bin2bcd_seq dut_a (.clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a), .busy(busy_a),
                     .done(done_a), .bcd_out(bcd_a), .digit_en(en_a), .ovf(ovf_a));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .start(start_b),
                     .bin_in(bin_b), .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
                     .digit_en(en_b), .ovf(ovf_b));
  int passed = 0, total = 0;
  exp_t q_a[$], q_b[$];
  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask
  // decimal digits by repeated division; anything left above the top digit is overflow
  function automatic exp_t model(input longint v, input int digits);
    exp_t e;
    longint r = v;
    int top = 0;
    e = '{default: 0};
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
      if (e.bcd[4*i +: 4] != 0) top = i;
    end
    e.ovf = r != 0;
    for (int i = 0; i < digits; i++) e.en[i] = e.ovf || i <= top;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_bcd", bcd_a, e.bcd);
        chk("a_digit_en", en_a, e.en);
        chk("a_ovf", ovf_a, e.ovf);
        chk("a_latency", cyc, e.cyc);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_b) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_bcd", bcd_b, e.bcd);
        chk("b_digit_en", en_b, e.en);
        chk("b_ovf", ovf_b, e.ovf);
        chk("b_latency", cyc, e.cyc);
      end
    end
  end
  task automatic go_a(input logic [31:0] v);
    exp_t e;
    int n = 0;
    while (busy_a && n < 200) begin @(negedge clk); n++; end
    if (busy_a) chk("a_busy_timeout", 1, 0);
    bin_a = v;
    start_a = 1;
    e = model(v, 10);
    e.cyc = cyc + 1 + 32;
    q_a.push_back(e);
    @(negedge clk);
    start_a = 0;
    chk("a_busy_after_start", busy_a, 1);
  endtask
  task automatic go_b(input logic [7:0] v);
    exp_t e;
    int n = 0;
    while (busy_b && n < 200) begin @(negedge clk); n++; end
    if (busy_b) chk("b_busy_timeout", 1, 0);
    bin_b = v;
    start_b = 1;
    e = model(v, 2);
    e.cyc = cyc + 1 + 8;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 0;
    chk("b_busy_after_start", busy_b, 1);
  endtask
  task automatic drain;
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      chk("drain_timeout", q_a.size() + q_b.size(), 0);
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    int n;
    logic [7:0] b_dir [5] = '{8'd255, 8'd99, 8'd7, 8'd0, 8'd100};
    start_a = 0; bin_a = 0; start_b = 0; bin_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bcd", bcd_a, 0);
    chk("rst_digit_en", en_a, 1);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_b_digit_en", en_b, 1);
    rst_n = 1;
    @(negedge clk);
    go_a(0); drain;
    go_a(32'd12345678); drain;
    go_a(32'hFFFFFFFF); drain;
    foreach (b_dir[i]) begin go_b(b_dir[i]); drain; end
    for (int i = 0; i < 15; i++) begin
      go_a($urandom);
      go_b(8'($urandom));
      drain;
    end
    go_a(32'd123456);
    repeat (4) @(negedge clk);
    bin_a = 32'd500; start_a = 1;
    @(negedge clk); start_a = 0;
    repeat (14) @(negedge clk);
    start_a = 1;
    @(negedge clk); start_a = 0;
    drain;
    go_a(32'd777);
    n = 0;
    while (!done_a && n < 100) begin @(negedge clk); n++; end
    chk("a_done_seen", done_a, 1);
    go_a(32'd42);
    repeat (10) begin @(negedge clk); chk("a_hold_prev", bcd_a, 40'h777); end
    drain;
    go_a(32'd999);
    repeat (9) @(negedge clk);
    rst_n = 0;
    q_a.delete();
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_bcd", bcd_a, 0);
    chk("abort_digit_en", en_a, 1);
    chk("abort_ovf", ovf_a, 0);
    repeat (3) begin @(negedge clk); chk("abort_no_done", done_a, 0); end
    rst_n = 1;
    @(negedge clk);
    go_a(32'd999); drain;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It replaces the free-running 32-bit score converter with a start/busy/done handshake, configurable input width and digit count, a leading-zero blanking mask and an overflow flag. It sits between the score/game logic and the 7-segment/VGA digit renderers; results are held stable until the next conversion completes.

Parameters:
BIN_W, 32, width of the binary input (>=1)
DIGITS, 10, number of BCD digits produced (>=1); 10 covers a full 32-bit unsigned value
CNT_W, $clog2(BIN_W+1), width of the internal bit counter (derived; not to be overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only when busy=0
bin_in  input  BIN_W  unsigned binary value, captured on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd_out/digit_en/ovf just updated
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in [3:0]
digit_en  output  DIGITS  1 = digit is significant (leading-zero blanking mask)
ovf  output  1  result exceeded DIGITS digits; bcd_out holds low-order digits only

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, digit_en=1 (bit 0 only), ovf=0, internal shift/work registers and counter cleared.
- States: IDLE, SHIFT.
- IDLE: busy=0. On edge with start=1: bin shift reg <= bin_in, BCD work reg <= 0, ovf work flag <= 0, counter <= BIN_W, go SHIFT, busy=1.
- SHIFT, each edge: (1) every work digit >=5 gets +3 (4-bit, no carry between digits); (2) work reg shifts left 1, LSB <= MSB of bin shift reg; bin shift reg shifts left 1; (3) bit shifted out of the top work digit ORs into the ovf work flag; counter decrements.
- Edge on which counter goes 1->0: state<=IDLE, busy<=0, bcd_out<=final work reg (post-shift value of that edge), ovf<=ovf work flag, digit_en updated, done<=1.
- done is high for exactly one cycle; cleared on the next edge unless another conversion completes on that edge (impossible for BIN_W>=1).
- Latency: start accepted at edge 0 -> done=1 and outputs valid after edge BIN_W. Throughput: one conversion per BIN_W+1 cycles at best.
- start while busy=1: ignored, no effect on the running conversion, not queued.
- start during the done cycle (state IDLE): accepted; new conversion begins, outputs hold previous result until its own done.
- bin_in changes while busy: no effect (captured at start only).
- digit_en[i] = 1 if any digit j>=i is nonzero; digit_en[0] always 1. If ovf=1, digit_en = all ones.
- bcd_out, digit_en, ovf change only on reset or on a done edge.
- Reset mid-conversion: aborts immediately, all outputs to reset values, no done pulse.
- DIGITS smaller than needed for BIN_W is legal; overflow detection covers it. DIGITS larger is legal; upper digits stay 0.

Test Plan:
- Reset then start with bin_in=0 (defaults) -> done exactly 32 cycles after start edge; bcd_out=0x0000000000, digit_en=10'b0000000001, ovf=0.
- bin_in=32'd12345678 -> bcd_out=0x0012345678, digit_en=10'b0011111111, ovf=0; then bin_in=32'hFFFFFFFF -> bcd_out=0x4294967295, digit_en all ones, ovf=0.
- BIN_W=8, DIGITS=2, bin_in=8'd255 -> ovf=1, bcd_out=0x55, digit_en=2'b11; bin_in=8'd99 -> ovf=0, bcd_out=0x99; bin_in=8'd7 -> bcd_out=0x07, digit_en=2'b01.
- Start pulses on cycles 5 and 20 after an accepted start with bin_in changing to 500 -> ignored; result is original value, single done pulse.
- Start asserted on the done cycle with bin_in=42 -> accepted; previous result held until second done, then bcd_out=0x0000000042.
- rst_n low 10 cycles into conversion of 999 -> busy=0, bcd_out=0 immediately (asynchronous), no done pulse; subsequent start of 999 completes normally with bcd_out=0x0000000999.
